// File: rtl/video_pkg.sv
// video_pkg: shared video constants, pixel type and line-buffer FSM states
//   H_PIX / V_LINES   : visible raster size
//   WORDS_PER_LINE    : 128-bit SDRAM words per line (8 RGB565 pixels each)
//   pixel_t           : one RGB565 pixel
//   lb_state_t        : line-buffer fetch FSM states
package video_pkg;
    localparam int H_PIX          = 640;
    localparam int V_LINES        = 480;
    localparam int WORDS_PER_LINE = 80;
    typedef logic [15:0] pixel_t;
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_GAP, ST_LINE_END} lb_state_t;
endpackage

// File: rtl/lb_dpram.sv
// lb_dpram: ping-pong line RAM, two banks of WORDS_PER_LINE x 128-bit words
//   i_clk                              : clock
//   i_we, i_wbank, i_wword, i_wdata    : synchronous write port
//   i_rbank, i_rword -> o_rdata        : read port, registered (1-cycle latency)
module lb_dpram
    import video_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_we,
    input  logic         i_wbank,
    input  logic [6:0]   i_wword,
    input  logic [127:0] i_wdata,
    input  logic         i_rbank,
    input  logic [6:0]   i_rword,
    output logic [127:0] o_rdata
);
    logic [127:0] r_mem [2*WORDS_PER_LINE];
    logic [7:0]   w_waddr;
    logic [7:0]   w_raddr;

    assign w_waddr = (i_wbank ? 8'(WORDS_PER_LINE) : 8'd0) + {1'b0, i_wword};
    assign w_raddr = (i_rbank ? 8'(WORDS_PER_LINE) : 8'd0) + {1'b0, i_rword};

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[w_waddr] <= i_wdata;
        o_rdata <= r_mem[w_raddr];
    end
endmodule

// File: rtl/lb_sdram_fetch.sv
// lb_sdram_fetch: fetches video lines from SDRAM into a ping-pong line RAM and serves pixels
//   clk, reset (async, active-low)
//   new_frame, DrawX, DrawY              : raster position and frame start
//   lb_sdram_Wait/ac/data, rd/addr       : arbiter line-buffer channel
//   lb_Busy, lb_done, lb_overrun         : status towards the arbiter
//   pixel_rgb                            : pixel at (DrawX, DrawY), 1-cycle latency
module lb_sdram_fetch
    import video_pkg::*;
#(
    parameter logic [21:0] FB_BASE = 22'h000000,
    parameter int          FETCH_X = 790
)(
    input  logic         clk,
    input  logic         reset,
    input  logic         new_frame,
    input  logic [9:0]   DrawX,
    input  logic [9:0]   DrawY,
    input  logic         lb_sdram_Wait,
    input  logic         lb_sdram_ac,
    input  logic [127:0] lb_sdram_data,
    output logic         lb_sdram_rd,
    output logic [21:0]  lb_sdram_addr,
    output logic         lb_Busy,
    output logic         lb_done,
    output pixel_t       pixel_rgb,
    output logic         lb_overrun
);
    lb_state_t    r_state;
    logic [8:0]   r_line;
    logic [6:0]   r_word;
    logic         r_pend;
    logic         r_abort;
    logic         r_busy;
    logic         r_done;
    logic         r_ovr;
    logic         r_pvalid;
    logic [2:0]   r_psel;
    logic [127:0] w_rdata;
    logic [6:0]   w_rword;
    logic         w_trig;
    logic         w_rd;
    logic         w_we;

    assign w_trig        = DrawX == 10'(FETCH_X) && DrawY <= 10'(V_LINES - 3);
    // rd follows Wait combinationally so a withdrawn grant drops the request at once
    assign w_rd          = r_state == ST_REQ && !lb_sdram_Wait;
    // a word acknowledged after (or together with) new_frame belongs to the aborted line
    assign w_we          = w_rd && lb_sdram_ac && !r_abort && !new_frame;
    assign lb_sdram_rd   = w_rd;
    assign lb_sdram_addr = FB_BASE + 22'(r_line) * 22'(WORDS_PER_LINE) + 22'(r_word);
    assign lb_Busy       = r_busy;
    assign lb_done       = r_done;
    assign lb_overrun    = r_ovr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_line  <= '0;
            r_word  <= '0;
            r_pend  <= 1'b0;
            r_abort <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ovr <= w_trig && r_busy && !new_frame;
            if (new_frame) r_done <= 1'b0;
            // an outstanding request must see its ac before the restart
            if (new_frame && w_rd && !lb_sdram_ac) r_abort <= 1'b1;
            else if (new_frame || (r_abort && r_state == ST_REQ && (lb_sdram_ac || lb_sdram_Wait))) begin
                r_abort <= 1'b0;
                r_line  <= '0;
                r_word  <= '0;
                r_pend  <= 1'b1;
                r_busy  <= 1'b1;
                r_state <= (r_state == ST_REQ && lb_sdram_ac) ? ST_GAP : ST_REQ;
            end else begin
                case (r_state)
                    ST_IDLE: if (w_trig) begin
                        r_line  <= 9'(DrawY + 10'd2);
                        r_word  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_REQ;
                    end
                    ST_REQ: if (w_rd && lb_sdram_ac) begin
                        if (r_word == 7'(WORDS_PER_LINE - 1)) r_state <= ST_LINE_END;
                        else begin
                            r_word  <= r_word + 7'd1;
                            r_state <= ST_GAP;
                        end
                    end
                    ST_GAP: r_state <= ST_REQ;
                    ST_LINE_END: begin
                        if (r_line == 9'(V_LINES - 1)) r_done <= 1'b1;
                        // the only second queued line is line 1 of a frame start
                        if (r_pend) begin
                            r_pend  <= 1'b0;
                            r_line  <= 9'd1;
                            r_word  <= '0;
                            r_state <= ST_REQ;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    // keep the read index inside a bank during horizontal blanking
    assign w_rword = (DrawX[9:3] < 7'(WORDS_PER_LINE)) ? DrawX[9:3] : 7'd0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pvalid <= 1'b0;
            r_psel   <= '0;
        end else begin
            r_pvalid <= DrawX < 10'(H_PIX) && DrawY < 10'(V_LINES);
            r_psel   <= DrawX[2:0];
        end
    end

    assign pixel_rgb = r_pvalid ? w_rdata[{r_psel, 4'd0} +: 16] : '0;

    lb_dpram u_ram (
        .i_clk   (clk),
        .i_we    (w_we),
        .i_wbank (r_line[0]),
        .i_wword (r_word),
        .i_wdata (lb_sdram_data),
        .i_rbank (DrawY[0]),
        .i_rword (w_rword),
        .o_rdata (w_rdata)
    );
endmodule

// File: tb/tb_lb_sdram_fetch.sv
// tb_lb_sdram_fetch: randomized self-checking bench for lb_sdram_fetch with an arbiter model
module tb_lb_sdram_fetch;
    logic         clk = 0, reset = 0, new_frame = 0, lb_sdram_Wait = 0, lb_sdram_ac = 0;
    logic [9:0]   DrawX = 0, DrawY = 0;
    logic [127:0] lb_sdram_data = '0;
    logic         lb_sdram_rd, lb_Busy, lb_done, lb_overrun;
    logic [21:0]  lb_sdram_addr;
    logic [15:0]  pixel_rgb;
    int           total = 0, bad = 0;
    int           lat = 3, cnt = 0, cyc = 0, last_ac_cyc = 0, glitches = 0;
    logic [15:0]  mask = 0;
    logic [21:0]  req_addr = 0;
    int           ac_log[$];

    lb_sdram_fetch dut (
        .clk(clk), .reset(reset), .new_frame(new_frame), .DrawX(DrawX), .DrawY(DrawY),
        .lb_sdram_Wait(lb_sdram_Wait), .lb_sdram_ac(lb_sdram_ac), .lb_sdram_data(lb_sdram_data),
        .lb_sdram_rd(lb_sdram_rd), .lb_sdram_addr(lb_sdram_addr), .lb_Busy(lb_Busy),
        .lb_done(lb_done), .pixel_rgb(pixel_rgb), .lb_overrun(lb_overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // framebuffer contents: pixel k of word a, scrambled by the current mask
    function automatic logic [15:0] pat(int a, int k, logic [15:0] m);
        return 16'(a * 8 + k - 640) ^ m;
    endfunction

    function automatic logic [127:0] word_of(int a, logic [15:0] m);
        logic [127:0] w;
        for (int k = 0; k < 8; k++) w[k*16 +: 16] = pat(a, k, m);
        return w;
    endfunction

    function automatic int seq_diff(int e[$]);
        for (int i = 0; i < e.size() || i < ac_log.size(); i++)
            if (i >= e.size() || i >= ac_log.size() || ac_log[i] != e[i]) return i;
        return -1;
    endfunction

    // arbiter: ac arrives 'lat' granted cycles after rd, data valid with ac
    always @(posedge clk) begin
        #2;
        if (!reset || lb_sdram_ac) begin
            lb_sdram_ac = 0;
            cnt = 0;
        end else if (lb_sdram_rd && !lb_sdram_Wait) begin
            if (cnt == 0) req_addr = lb_sdram_addr;
            else if (lb_sdram_addr != req_addr) glitches++;
            cnt++;
            if (cnt == lat) begin
                lb_sdram_ac = 1;
                cnt = 0;
                lb_sdram_data = word_of(int'(lb_sdram_addr), mask);
                ac_log.push_back(int'(lb_sdram_addr));
                last_ac_cyc = cyc;
            end
        end else cnt = 0;
    end

    task automatic wait_idle(string tag);
        int n = 0;
        while (lb_Busy && n < 3000) begin @(negedge clk); n++; end
        if (lb_Busy) begin total++; bad++; $display("FAIL %s_timeout: lb_Busy=1 after %0d cycles, expected 0", tag, n); end
    endtask

    task automatic pulse_nf();
        new_frame = 1;
        @(negedge clk);
        new_frame = 0;
    endtask

    task automatic trig(int y);
        DrawX = 10'd790;
        DrawY = 10'(y);
        @(negedge clk);
        DrawX = 0;
        DrawY = 0;
    endtask

    task automatic test_reset();
        reset = 0;
        repeat (3) @(negedge clk);
        total++; if (lb_sdram_rd !== 1'b0) begin bad++; $display("FAIL reset_rd: got %b expected 0", lb_sdram_rd); end
        total++; if (lb_sdram_addr !== 22'd0) begin bad++; $display("FAIL reset_addr: got %0d expected 0", lb_sdram_addr); end
        total++; if (lb_Busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", lb_Busy); end
        total++; if (lb_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", lb_done); end
        total++; if (pixel_rgb !== 16'd0) begin bad++; $display("FAIL reset_pixel: got %h expected 0", pixel_rgb); end
        total++; if (lb_overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b expected 0", lb_overrun); end
        reset = 1;
        @(negedge clk);
    endtask

    task automatic test_frame_start();
        int e[$];
        int d;
        mask = 0; lat = 3; glitches = 0; ac_log.delete();
        pulse_nf();
        total++; if (lb_Busy !== 1'b1) begin bad++; $display("FAIL fs_busy: got %b expected 1", lb_Busy); end
        wait_idle("fs");
        for (int a = 0; a < 160; a++) e.push_back(a);
        d = seq_diff(e);
        total++; if (d != -1) begin bad++; $display("FAIL fs_seq: differs at %0d, got %0d reads expected 160", d, ac_log.size()); end
        total++; if (cyc - last_ac_cyc != 2) begin bad++; $display("FAIL fs_busy_fall: got %0d cycles after last ac expected 2", cyc - last_ac_cyc); end
        total++; if (lb_done !== 1'b0) begin bad++; $display("FAIL fs_done: got %b expected 0", lb_done); end
        total++; if (glitches != 0) begin bad++; $display("FAIL fs_addr_stable: got %0d changes expected 0", glitches); end
    endtask

    task automatic test_pixels();
        int x, y;
        DrawY = 1;
        for (int i = 0; i < 8; i++) begin
            DrawX = 10'(i);
            @(negedge clk);
            total++; if (pixel_rgb !== 16'(i)) begin bad++; $display("FAIL pix_line1_x%0d: got %h expected %h", i, pixel_rgb, 16'(i)); end
        end
        repeat (6) begin
            y = $urandom_range(0, 1);
            x = $urandom_range(0, 639);
            DrawY = 10'(y); DrawX = 10'(x);
            @(negedge clk);
            total++; if (pixel_rgb !== pat(y * 80 + x / 8, x % 8, 0)) begin bad++; $display("FAIL pix_rand(%0d,%0d): got %h expected %h", x, y, pixel_rgb, pat(y * 80 + x / 8, x % 8, 0)); end
        end
        DrawY = 1; DrawX = 639;
        @(negedge clk);
        total++; if (pixel_rgb !== pat(159, 7, 0)) begin bad++; $display("FAIL pix_x639: got %h expected %h", pixel_rgb, pat(159, 7, 0)); end
        DrawX = 640;
        @(negedge clk);
        total++; if (pixel_rgb !== 16'd0) begin bad++; $display("FAIL pix_x640: got %h expected 0", pixel_rgb); end
        DrawY = 480; DrawX = 5;
        @(negedge clk);
        total++; if (pixel_rgb !== 16'd0) begin bad++; $display("FAIL pix_y480: got %h expected 0", pixel_rgb); end
        DrawX = 0; DrawY = 0;
    endtask

    task automatic test_wait();
        int e[$];
        int n = 0, d;
        mask = 16'($urandom); lat = 3; glitches = 0; ac_log.delete();
        pulse_nf();
        while (!(lb_sdram_rd && lb_sdram_addr == 22'd37) && n < 1000) begin @(negedge clk); n++; end
        total++;
        if (n >= 1000) begin bad++; $display("FAIL wait_reach37: rd at word 37 never seen, expected within 1000 cycles"); end
        else begin
            lb_sdram_Wait = 1;
            #1;
            total++; if (lb_sdram_rd !== 1'b0) begin bad++; $display("FAIL wait_drop: rd got %b expected 0", lb_sdram_rd); end
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                total++; if (lb_sdram_rd !== 1'b0 || lb_sdram_addr !== 22'd37) begin bad++; $display("FAIL wait_hold%0d: rd=%b addr=%0d expected rd=0 addr=37", i, lb_sdram_rd, lb_sdram_addr); end
            end
            lb_sdram_Wait = 0;
        end
        wait_idle("wait");
        for (int a = 0; a < 160; a++) e.push_back(a);
        d = seq_diff(e);
        total++; if (d != -1) begin bad++; $display("FAIL wait_seq: differs at %0d, got %0d reads expected 160", d, ac_log.size()); end
        total++; if (glitches != 0) begin bad++; $display("FAIL wait_addr_stable: got %0d changes expected 0", glitches); end
    endtask

    task automatic test_overrun();
        int e[$];
        int y, n = 0, d;
        mask = 16'($urandom); lat = 3;
        pulse_nf();
        wait_idle("ovr_fill");
        y = $urandom_range(0, 470);
        ac_log.delete();
        trig(y);
        total++; if (lb_overrun !== 1'b0 || lb_Busy !== 1'b1) begin bad++; $display("FAIL ovr_accept: overrun=%b busy=%b expected 0/1", lb_overrun, lb_Busy); end
        while (ac_log.size() < 10 && n < 1000) begin @(negedge clk); n++; end
        trig($urandom_range(0, 477));
        total++; if (lb_overrun !== 1'b1) begin bad++; $display("FAIL ovr_pulse: got %b expected 1", lb_overrun); end
        @(negedge clk);
        total++; if (lb_overrun !== 1'b0) begin bad++; $display("FAIL ovr_one_cycle: got %b expected 0", lb_overrun); end
        wait_idle("ovr");
        for (int w = 0; w < 80; w++) e.push_back((y + 2) * 80 + w);
        d = seq_diff(e);
        total++; if (d != -1) begin bad++; $display("FAIL ovr_seq: differs at %0d, got %0d reads expected 80 of line %0d", d, ac_log.size(), y + 2); end
    endtask

    task automatic test_collision();
        int e[$];
        int n = 0, d;
        mask = 16'($urandom); lat = 3; ac_log.delete();
        trig($urandom_range(0, 470));
        while (!(ac_log.size() >= 5 && !lb_sdram_ac) && n < 1000) begin @(negedge clk); n++; end
        lb_sdram_Wait = 1;
        @(negedge clk);
        ac_log.delete();
        new_frame = 1; DrawX = 10'd790; DrawY = 10'($urandom_range(0, 477));
        @(negedge clk);
        new_frame = 0; DrawX = 0; DrawY = 0;
        total++; if (lb_overrun !== 1'b0) begin bad++; $display("FAIL coll_overrun: got %b expected 0", lb_overrun); end
        lb_sdram_Wait = 0;
        wait_idle("coll");
        for (int a = 0; a < 160; a++) e.push_back(a);
        d = seq_diff(e);
        total++; if (d != -1) begin bad++; $display("FAIL coll_seq: differs at %0d, got %0d reads expected 160", d, ac_log.size()); end
    endtask

    task automatic test_frame_done();
        int e[$];
        int ys[6];
        int d, x;
        mask = 16'($urandom); lat = 1;
        pulse_nf();
        wait_idle("fd_fill");
        ac_log.delete();
        ys[0] = 0; ys[1] = 1; ys[2] = $urandom_range(2, 475); ys[3] = $urandom_range(2, 475); ys[4] = 476; ys[5] = 477;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) begin
                total++; if (lb_done !== 1'b0) begin bad++; $display("FAIL fd_done_early: got %b expected 0", lb_done); end
            end
            trig(ys[i]);
            wait_idle("fd_line");
            for (int w = 0; w < 80; w++) e.push_back((ys[i] + 2) * 80 + w);
        end
        d = seq_diff(e);
        total++; if (d != -1) begin bad++; $display("FAIL fd_seq: differs at %0d, got %0d reads expected %0d", d, ac_log.size(), e.size()); end
        total++; if (ac_log.size() == 0 || ac_log[ac_log.size() - 1] != 38399) begin bad++; $display("FAIL fd_last_addr: got %0d expected 38399", ac_log.size() ? ac_log[ac_log.size() - 1] : -1); end
        total++; if (lb_done !== 1'b1) begin bad++; $display("FAIL fd_done: got %b expected 1", lb_done); end
        for (int yy = 478; yy < 480; yy++) begin
            x = $urandom_range(0, 639);
            DrawY = 10'(yy); DrawX = 10'(x);
            @(negedge clk);
            total++; if (pixel_rgb !== pat(yy * 80 + x / 8, x % 8, mask)) begin bad++; $display("FAIL fd_pix(%0d,%0d): got %h expected %h", x, yy, pixel_rgb, pat(yy * 80 + x / 8, x % 8, mask)); end
        end
        DrawX = 0; DrawY = 0;
        pulse_nf();
        total++; if (lb_done !== 1'b0) begin bad++; $display("FAIL fd_done_clear: got %b expected 0", lb_done); end
        wait_idle("fd_restart");
    endtask

    task automatic test_abort();
        int e[$];
        logic [15:0] m_old;
        int n = 0, d;
        lat = 3; m_old = 16'($urandom); mask = m_old;
        pulse_nf();
        wait_idle("ab_fill");
        mask = ~m_old;
        ac_log.delete();
        trig(98);
        while (!(lb_sdram_rd && lb_sdram_addr == 22'd8012) && n < 1000) begin @(negedge clk); n++; end
        pulse_nf();
        total++; if (lb_done !== 1'b0) begin bad++; $display("FAIL ab_done: got %b expected 0", lb_done); end
        n = 0;
        while (!(ac_log.size() >= 13 && !lb_sdram_ac) && n < 100) begin @(negedge clk); n++; end
        DrawY = 0; DrawX = 88;
        @(negedge clk);
        total++; if (pixel_rgb !== pat(8011, 0, mask)) begin bad++; $display("FAIL ab_word11: got %h expected %h", pixel_rgb, pat(8011, 0, mask)); end
        DrawX = 96;
        @(negedge clk);
        total++; if (pixel_rgb !== pat(12, 0, m_old)) begin bad++; $display("FAIL ab_word12_kept: got %h expected %h", pixel_rgb, pat(12, 0, m_old)); end
        DrawX = 0;
        wait_idle("ab");
        for (int w = 0; w <= 12; w++) e.push_back(8000 + w);
        for (int a = 0; a < 160; a++) e.push_back(a);
        d = seq_diff(e);
        total++; if (d != -1) begin bad++; $display("FAIL ab_seq: differs at %0d, got %0d reads expected %0d", d, ac_log.size(), e.size()); end
    endtask

    task automatic test_async_reset();
        int n = 0;
        lat = 3;
        pulse_nf();
        while (!lb_sdram_rd && n < 100) begin @(negedge clk); n++; end
        #1 reset = 0;
        #1;
        total++; if (lb_sdram_rd !== 1'b0) begin bad++; $display("FAIL ar_rd: got %b expected 0", lb_sdram_rd); end
        total++; if (lb_Busy !== 1'b0 || lb_sdram_addr !== 22'd0) begin bad++; $display("FAIL ar_state: busy=%b addr=%0d expected 0/0", lb_Busy, lb_sdram_addr); end
        repeat (2) @(negedge clk);
        reset = 1;
        repeat (5) @(negedge clk);
        total++; if (lb_sdram_rd !== 1'b0 || lb_Busy !== 1'b0) begin bad++; $display("FAIL ar_idle: rd=%b busy=%b expected 0/0", lb_sdram_rd, lb_Busy); end
    endtask

    initial begin
        test_reset();
        test_frame_start();
        test_pixels();
        test_wait();
        test_overrun();
        test_collision();
        test_frame_done();
        test_abort();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
